// File: rtl/operand_collector.sv
// operand_collector: gathers up to three vec4 source operands from a banked
// register file, splitting bank conflicts into extra read rounds, then applies
// swizzle/abs/negate. Latency: 3 cycles accept->out_valid without conflicts,
// +2 per extra read round. Backpressure: in_ready only in IDLE; results and
// ctrl_o are held in DONE until out_ready.
// Ports: clk/rst; in_valid/in_ready + readEnN/readAddrN/opN_* /ALUSrc/imm/ctrl_in
// (instruction); flush (kill); rf_rd_* (bank read ports, data 1 cycle after
// enable); out_valid/out_ready + op1_o..op3_o/ctrl_o (to execute).
module operand_collector #(
   parameter int TotalNumBank = 8,
   parameter int AddrWidth    = 5,
   parameter int CtrlWidth    = 40
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [TotalNumBank-1:0]           readEn1,
   input  logic [AddrWidth-1:0]              readAddr1,
   input  logic [TotalNumBank-1:0]           readEn2,
   input  logic [AddrWidth-1:0]              readAddr2,
   input  logic [TotalNumBank-1:0]           readEn3,
   input  logic [AddrWidth-1:0]              readAddr3,
   input  logic [7:0]                        op1_swizzle,
   input  logic                              op1_negate,
   input  logic                              op1_abs,
   input  logic [7:0]                        op2_swizzle,
   input  logic                              op2_negate,
   input  logic                              op2_abs,
   input  logic [7:0]                        op3_swizzle,
   input  logic                              op3_negate,
   input  logic                              op3_abs,
   input  logic                              ALUSrc,
   input  logic [31:0]                       imm,
   input  logic [CtrlWidth-1:0]              ctrl_in,
   input  logic                              flush,
   output logic [TotalNumBank-1:0]           rf_rd_en,
   output logic [TotalNumBank*AddrWidth-1:0] rf_rd_addr,
   input  logic [TotalNumBank*128-1:0]       rf_rd_data,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [127:0]                      op1_o,
   output logic [127:0]                      op2_o,
   output logic [127:0]                      op3_o,
   output logic [CtrlWidth-1:0]              ctrl_o
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_DONE} state_t;

   localparam logic [TotalNumBank-1:0] LP_ONE = {{(TotalNumBank-1){1'b0}}, 1'b1};

   state_t                            r_state;
   logic                              r_in_ready;
   logic                              r_out_valid;
   logic [TotalNumBank-1:0]           r_rd_en;
   logic [TotalNumBank*AddrWidth-1:0] r_rd_addr;
   logic [TotalNumBank-1:0]           r_bank [3];
   logic [AddrWidth-1:0]              r_addr [3];
   logic [7:0]                        r_swz  [3];
   logic [2:0]                        r_neg;
   logic [2:0]                        r_abs;
   logic [2:0]                        r_pending;
   logic [2:0]                        r_issued;
   logic [127:0]                      r_op   [3];
   logic [CtrlWidth-1:0]              r_ctrl;

   logic [TotalNumBank-1:0]           w_en_in    [3];
   logic [AddrWidth-1:0]              w_addr_in  [3];
   logic [2:0]                        w_pend_in;
   logic [TotalNumBank-1:0]           w_src_bank [3];
   logic [AddrWidth-1:0]              w_src_addr [3];
   logic [2:0]                        w_src_pend;
   logic [2:0]                        w_remain;
   logic [2:0]                        w_sel;
   logic [TotalNumBank-1:0]           w_nxt_en;
   logic [TotalNumBank*AddrWidth-1:0] w_nxt_addr;
   logic [127:0]                      w_raw      [3];
   logic [127:0]                      w_mod      [3];
   logic [31:0]                       w_comp;

   // Keep only the lowest set bit so a malformed select still names one bank.
   function automatic logic [TotalNumBank-1:0] f_lowest(input logic [TotalNumBank-1:0] v);
      return v & (~v + LP_ONE);
   endfunction

   // A lower operand blocks a higher one only when it is still waiting on the
   // same bank at a different row; same row is served by one shared read.
   function automatic logic f_conflict(input logic                    lo_pend,
                                       input logic [TotalNumBank-1:0] lo_bank,
                                       input logic [TotalNumBank-1:0] hi_bank,
                                       input logic [AddrWidth-1:0]    lo_addr,
                                       input logic [AddrWidth-1:0]    hi_addr);
      return lo_pend && (lo_bank == hi_bank) && (lo_addr != hi_addr);
   endfunction

   always_comb begin
      w_en_in[0]   = f_lowest(readEn1);
      w_en_in[1]   = f_lowest(readEn2);
      w_en_in[2]   = f_lowest(readEn3);
      w_addr_in[0] = readAddr1;
      w_addr_in[1] = readAddr2;
      w_addr_in[2] = readAddr3;
      w_pend_in    = {|readEn3, (|readEn2) & ~ALUSrc, |readEn1};
      w_remain     = r_pending & ~r_issued;
   end

   // The next read round is planned either at acceptance (from the inputs)
   // or at the end of a CAPTURE (from what is still outstanding), so the
   // bank enables can be registered on entry to ISSUE.
   always_comb begin
      for (int n = 0; n < 3; n++) begin
         w_src_bank[n] = (r_state == S_IDLE) ? w_en_in[n]   : r_bank[n];
         w_src_addr[n] = (r_state == S_IDLE) ? w_addr_in[n] : r_addr[n];
      end
      w_src_pend = (r_state == S_IDLE) ? w_pend_in : w_remain;
      w_sel[0] = w_src_pend[0];
      w_sel[1] = w_src_pend[1]
               & ~f_conflict(w_src_pend[0], w_src_bank[0], w_src_bank[1], w_src_addr[0], w_src_addr[1]);
      w_sel[2] = w_src_pend[2]
               & ~f_conflict(w_src_pend[0], w_src_bank[0], w_src_bank[2], w_src_addr[0], w_src_addr[2])
               & ~f_conflict(w_src_pend[1], w_src_bank[1], w_src_bank[2], w_src_addr[1], w_src_addr[2]);
   end

   always_comb begin
      w_nxt_en   = '0;
      w_nxt_addr = '0;
      for (int n = 0; n < 3; n++) begin
         if (w_sel[n]) begin
            w_nxt_en = w_nxt_en | w_src_bank[n];
            for (int b = 0; b < TotalNumBank; b++) begin
               if (w_src_bank[n][b]) begin
                  w_nxt_addr[b*AddrWidth +: AddrWidth] =
                     w_nxt_addr[b*AddrWidth +: AddrWidth] | w_src_addr[n];
               end
            end
         end
      end
   end

   // Bank data -> swizzle -> abs -> negate, per operand.
   always_comb begin
      w_comp = '0;
      for (int n = 0; n < 3; n++) begin
         w_raw[n] = '0;
         w_mod[n] = '0;
         for (int b = 0; b < TotalNumBank; b++) begin
            if (r_bank[n][b]) begin
               w_raw[n] = w_raw[n] | rf_rd_data[b*128 +: 128];
            end
         end
         for (int i = 0; i < 4; i++) begin
            w_comp = w_raw[n][{r_swz[n][2*i +: 2], 5'b00000} +: 32];
            if (r_abs[n]) w_comp[31] = 1'b0;
            if (r_neg[n]) w_comp[31] = ~w_comp[31];
            w_mod[n][i*32 +: 32] = w_comp;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_rd_en     <= '0;
         r_rd_addr   <= '0;
         r_neg       <= '0;
         r_abs       <= '0;
         r_pending   <= '0;
         r_issued    <= '0;
         r_ctrl      <= '0;
         for (int n = 0; n < 3; n++) begin
            r_bank[n] <= '0;
            r_addr[n] <= '0;
            r_swz[n]  <= '0;
            r_op[n]   <= '0;
         end
      end else if (flush) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_rd_en     <= '0;
         r_rd_addr   <= '0;
         r_pending   <= '0;
         r_issued    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  for (int n = 0; n < 3; n++) begin
                     r_bank[n] <= w_en_in[n];
                     r_addr[n] <= w_addr_in[n];
                  end
                  r_swz[0]   <= op1_swizzle;
                  r_swz[1]   <= op2_swizzle;
                  r_swz[2]   <= op3_swizzle;
                  r_neg      <= {op3_negate, op2_negate, op1_negate};
                  r_abs      <= {op3_abs, op2_abs, op1_abs};
                  r_ctrl     <= ctrl_in;
                  r_pending  <= w_pend_in;
                  // Unused operands read as 0; an immediate is final here.
                  r_op[0]    <= '0;
                  r_op[1]    <= ALUSrc ? {4{imm}} : 128'd0;
                  r_op[2]    <= '0;
                  r_rd_en    <= w_nxt_en;
                  r_rd_addr  <= w_nxt_addr;
                  r_issued   <= w_sel;
                  r_in_ready <= 1'b0;
                  r_state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_rd_en   <= '0;
               r_rd_addr <= '0;
               r_state   <= S_CAPTURE;
            end
            S_CAPTURE: begin
               for (int n = 0; n < 3; n++) begin
                  if (r_issued[n]) r_op[n] <= w_mod[n];
               end
               r_pending <= w_remain;
               if (|w_remain) begin
                  r_rd_en   <= w_nxt_en;
                  r_rd_addr <= w_nxt_addr;
                  r_issued  <= w_sel;
                  r_state   <= S_ISSUE;
               end else begin
                  r_issued    <= '0;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready   = r_in_ready;
   assign out_valid  = r_out_valid;
   assign rf_rd_en   = r_rd_en;
   assign rf_rd_addr = r_rd_addr;
   assign op1_o      = r_op[0];
   assign op2_o      = r_op[1];
   assign op3_o      = r_op[2];
   assign ctrl_o     = r_ctrl;

endmodule

// File: tb/tb_operand_collector.sv
module tb_operand_collector;
   localparam int NB = 8;
   localparam int AW = 5;
   localparam int CW = 40;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid, in_ready;
   logic [NB-1:0]    readEn1, readEn2, readEn3;
   logic [AW-1:0]    readAddr1, readAddr2, readAddr3;
   logic [7:0]       op1_swizzle, op2_swizzle, op3_swizzle;
   logic             op1_negate, op2_negate, op3_negate;
   logic             op1_abs, op2_abs, op3_abs;
   logic             ALUSrc;
   logic [31:0]      imm;
   logic [CW-1:0]    ctrl_in;
   logic             flush;
   logic [NB-1:0]    rf_rd_en;
   logic [NB*AW-1:0] rf_rd_addr;
   logic [NB*128-1:0] rf_rd_data = '0;
   logic             out_valid;
   logic             out_ready;
   logic [127:0]     op1_o, op2_o, op3_o;
   logic [CW-1:0]    ctrl_o;

   logic [127:0]     rf_mem [NB][32];

   int               checks = 0;
   int               errors = 0;
   int               lat;
   int               n_iss;
   logic [NB-1:0]    log_en   [4];
   logic [NB*AW-1:0] log_addr [4];
   logic [NB-1:0]    or_en;

   operand_collector #(.TotalNumBank(NB), .AddrWidth(AW), .CtrlWidth(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .readEn1(readEn1), .readAddr1(readAddr1),
      .readEn2(readEn2), .readAddr2(readAddr2),
      .readEn3(readEn3), .readAddr3(readAddr3),
      .op1_swizzle(op1_swizzle), .op1_negate(op1_negate), .op1_abs(op1_abs),
      .op2_swizzle(op2_swizzle), .op2_negate(op2_negate), .op2_abs(op2_abs),
      .op3_swizzle(op3_swizzle), .op3_negate(op3_negate), .op3_abs(op3_abs),
      .ALUSrc(ALUSrc), .imm(imm), .ctrl_in(ctrl_in), .flush(flush),
      .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .op1_o(op1_o), .op2_o(op2_o), .op3_o(op3_o), .ctrl_o(ctrl_o)
   );

   always #5 clk = ~clk;

   // Register-file model: data returned exactly one cycle after the enable;
   // banks not read return a poison pattern.
   always @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
         rf_rd_data[b*128 +: 128] <= rf_rd_en[b] ? rf_mem[b][rf_rd_addr[b*AW +: AW]]
                                                  : {4{32'hDEADBEEF}};
      end
   end

   task automatic clear_inputs();
      in_valid = 0; readEn1 = '0; readEn2 = '0; readEn3 = '0;
      readAddr1 = '0; readAddr2 = '0; readAddr3 = '0;
      op1_swizzle = 8'hE4; op2_swizzle = 8'hE4; op3_swizzle = 8'hE4;
      op1_negate = 0; op2_negate = 0; op3_negate = 0;
      op1_abs = 0; op2_abs = 0; op3_abs = 0;
      ALUSrc = 0; imm = '0; ctrl_in = '0; flush = 0;
   endtask

   // Present one instruction and watch it until out_valid (bounded).
   task automatic run_instr();
      lat = -1; n_iss = 0; or_en = '0;
      for (int k = 0; k < 4; k++) begin log_en[k] = '0; log_addr[k] = '0; end
      in_valid = 1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 1) in_valid = 0;
         if (rf_rd_en != '0) begin
            if (n_iss < 4) begin
               log_en[n_iss] = rf_rd_en;
               log_addr[n_iss] = rf_rd_addr;
            end
            n_iss++;
            or_en = or_en | rf_rd_en;
         end
         if (out_valid === 1'b1) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic finish_hs();
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
   endtask

   task automatic test_reset();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %h want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %h want 0", out_valid); end
      checks++; if (rf_rd_en !== '0) begin errors++; $display("FAIL reset_rd_en got %h want 0", rf_rd_en); end
      checks++; if (rf_rd_addr !== '0) begin errors++; $display("FAIL reset_rd_addr got %h want 0", rf_rd_addr); end
      checks++; if ({op1_o, op2_o, op3_o} !== '0) begin errors++; $display("FAIL reset_ops got %h %h %h want 0", op1_o, op2_o, op3_o); end
      checks++; if (ctrl_o !== '0) begin errors++; $display("FAIL reset_ctrl got %h want 0", ctrl_o); end
   endtask

   task automatic test_no_conflict();
      clear_inputs();
      readEn1 = 8'h01; readAddr1 = 5'd3;
      readEn2 = 8'h02; readAddr2 = 5'd5;
      readEn3 = 8'h04; readAddr3 = 5'd7;
      ctrl_in = 40'hA512345678;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL nc_in_ready got %h want 1", in_ready); end
      run_instr();
      checks++; if (lat != 3) begin errors++; $display("FAIL nc_latency got %0d want 3", lat); end
      checks++; if (n_iss != 1) begin errors++; $display("FAIL nc_rounds got %0d want 1", n_iss); end
      checks++; if (log_en[0] !== 8'h07) begin errors++; $display("FAIL nc_rd_en got %h want 07", log_en[0]); end
      checks++; if (log_addr[0] !== 40'h0000001CA3) begin errors++; $display("FAIL nc_rd_addr got %h want 0000001ca3", log_addr[0]); end
      checks++; if (op1_o !== rf_mem[0][3]) begin errors++; $display("FAIL nc_op1 got %h want %h", op1_o, rf_mem[0][3]); end
      checks++; if (op2_o !== rf_mem[1][5]) begin errors++; $display("FAIL nc_op2 got %h want %h", op2_o, rf_mem[1][5]); end
      checks++; if (op3_o !== rf_mem[2][7]) begin errors++; $display("FAIL nc_op3 got %h want %h", op3_o, rf_mem[2][7]); end
      checks++; if (ctrl_o !== 40'hA512345678) begin errors++; $display("FAIL nc_ctrl got %h want a512345678", ctrl_o); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL nc_in_ready_done got %h want 0", in_ready); end
      finish_hs();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL nc_after_hs got ov=%h ir=%h want 0 1", out_valid, in_ready); end
   endtask

   task automatic test_conflict();
      clear_inputs();
      readEn1 = 8'h10; readAddr1 = 5'd1;
      readEn2 = 8'h10; readAddr2 = 5'd2;
      run_instr();
      checks++; if (lat != 5) begin errors++; $display("FAIL cf_latency got %0d want 5", lat); end
      checks++; if (n_iss != 2) begin errors++; $display("FAIL cf_rounds got %0d want 2", n_iss); end
      checks++; if (log_en[0] !== 8'h10 || log_en[1] !== 8'h10) begin errors++; $display("FAIL cf_rd_en got %h %h want 10 10", log_en[0], log_en[1]); end
      checks++; if (log_addr[0] !== 40'h0000100000 || log_addr[1] !== 40'h0000200000) begin errors++; $display("FAIL cf_rd_addr got %h %h want 0000100000 0000200000", log_addr[0], log_addr[1]); end
      checks++; if (op1_o !== rf_mem[4][1]) begin errors++; $display("FAIL cf_op1 got %h want %h", op1_o, rf_mem[4][1]); end
      checks++; if (op2_o !== rf_mem[4][2]) begin errors++; $display("FAIL cf_op2 got %h want %h", op2_o, rf_mem[4][2]); end
      checks++; if (op3_o !== '0) begin errors++; $display("FAIL cf_op3_unused got %h want 0", op3_o); end
      finish_hs();
   endtask

   task automatic test_three_rounds();
      clear_inputs();
      readEn1 = 8'h20; readAddr1 = 5'd0;
      readEn2 = 8'h20; readAddr2 = 5'd1;
      readEn3 = 8'h20; readAddr3 = 5'd2;
      run_instr();
      checks++; if (lat != 7) begin errors++; $display("FAIL tr_latency got %0d want 7", lat); end
      checks++; if (n_iss != 3) begin errors++; $display("FAIL tr_rounds got %0d want 3", n_iss); end
      checks++; if (log_addr[2] !== 40'h0004000000) begin errors++; $display("FAIL tr_rd_addr3 got %h want 0004000000", log_addr[2]); end
      checks++; if (op3_o !== rf_mem[5][2] || op1_o !== rf_mem[5][0]) begin errors++; $display("FAIL tr_ops got %h %h want %h %h", op1_o, op3_o, rf_mem[5][0], rf_mem[5][2]); end
      finish_hs();
   endtask

   task automatic test_share();
      clear_inputs();
      readEn1 = 8'h40; readAddr1 = 5'd9;
      readEn3 = 8'h40; readAddr3 = 5'd9;
      run_instr();
      checks++; if (lat != 3) begin errors++; $display("FAIL sh_latency got %0d want 3", lat); end
      checks++; if (n_iss != 1 || log_en[0] !== 8'h40) begin errors++; $display("FAIL sh_rd_en got rounds=%0d en=%h want 1 40", n_iss, log_en[0]); end
      checks++; if (log_addr[0] !== 40'h0240000000) begin errors++; $display("FAIL sh_rd_addr got %h want 0240000000", log_addr[0]); end
      checks++; if (op1_o !== rf_mem[6][9] || op3_o !== rf_mem[6][9]) begin errors++; $display("FAIL sh_ops got %h %h want %h", op1_o, op3_o, rf_mem[6][9]); end
      checks++; if (op2_o !== '0) begin errors++; $display("FAIL sh_op2_unused got %h want 0", op2_o); end
      finish_hs();
   endtask

   task automatic test_swizzle_mods();
      clear_inputs();
      rf_mem[0][31] = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
      rf_mem[1][31] = {4{32'h3F800000}};
      rf_mem[2][31] = {32'hBF800000, 32'h3F800000, 32'hBF800000, 32'h3F800000};
      readEn1 = 8'h01; readAddr1 = 5'd31; op1_swizzle = 8'h1B;
      readEn2 = 8'h02; readAddr2 = 5'd31; op2_negate = 1;
      readEn3 = 8'h04; readAddr3 = 5'd31; op3_negate = 1; op3_abs = 1;
      run_instr();
      checks++; if (op1_o !== {32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD}) begin errors++; $display("FAIL sw_reverse got %h want aaaaaaaabbbbbbbbccccccccdddddddd", op1_o); end
      checks++; if (op2_o !== {4{32'hBF800000}}) begin errors++; $display("FAIL sw_negate got %h want 4x bf800000", op2_o); end
      checks++; if (op3_o !== {4{32'hBF800000}}) begin errors++; $display("FAIL sw_abs_negate got %h want 4x bf800000", op3_o); end
      finish_hs();
   endtask

   task automatic test_imm();
      clear_inputs();
      readEn1 = 8'h01; readAddr1 = 5'd1;
      readEn2 = 8'h08; readAddr2 = 5'd4; op2_swizzle = 8'h1B;
      ALUSrc = 1; imm = 32'h40000000;
      run_instr();
      checks++; if (lat != 3) begin errors++; $display("FAIL im_latency got %0d want 3", lat); end
      checks++; if (op2_o !== {4{32'h40000000}}) begin errors++; $display("FAIL im_op2 got %h want 4x 40000000", op2_o); end
      checks++; if (or_en[3] !== 1'b0 || log_en[0] !== 8'h01) begin errors++; $display("FAIL im_bank3_read got or_en=%h en0=%h want bit3=0 en0=01", or_en, log_en[0]); end
      checks++; if (op1_o !== rf_mem[0][1]) begin errors++; $display("FAIL im_op1 got %h want %h", op1_o, rf_mem[0][1]); end
      finish_hs();
   endtask

   task automatic test_non_onehot();
      clear_inputs();
      readEn1 = 8'h34; readAddr1 = 5'd6;
      run_instr();
      checks++; if (log_en[0] !== 8'h04 || log_addr[0] !== 40'h0000001800) begin errors++; $display("FAIL no_rd got en=%h addr=%h want 04 0000001800", log_en[0], log_addr[0]); end
      checks++; if (op1_o !== rf_mem[2][6]) begin errors++; $display("FAIL no_op1 got %h want %h", op1_o, rf_mem[2][6]); end
      finish_hs();
   endtask

   task automatic test_backpressure_reset();
      clear_inputs();
      readEn1 = 8'h01; readAddr1 = 5'd2;
      readEn2 = 8'h80; readAddr2 = 5'd11;
      ctrl_in = 40'h0F0F0F0F0F;
      run_instr();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || op1_o !== rf_mem[0][2] ||
             op2_o !== rf_mem[7][11] || op3_o !== '0 || ctrl_o !== 40'h0F0F0F0F0F) begin
            errors++;
            $display("FAIL bp_hold cycle %0d got ov=%h ir=%h op1=%h op2=%h ctrl=%h", c, out_valid, in_ready, op1_o, op2_o, ctrl_o);
         end
      end
      finish_hs();
      // Start a new instruction and hit it with reset while in ISSUE.
      clear_inputs();
      readEn1 = 8'h02; readAddr1 = 5'd3;
      in_valid = 1;
      @(negedge clk);
      in_valid = 0;
      checks++; if (rf_rd_en !== 8'h02) begin errors++; $display("FAIL rs_issue got %h want 02", rf_rd_en); end
      rst = 1;
      #1;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || rf_rd_en !== '0) begin errors++; $display("FAIL rs_idle got ir=%h ov=%h en=%h want 1 0 0", in_ready, out_valid, rf_rd_en); end
      @(negedge clk);
      rst = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b0 || rf_rd_en !== '0) begin errors++; $display("FAIL rs_no_output cycle %0d got ov=%h en=%h want 0 0", c, out_valid, rf_rd_en); end
      end
   endtask

   task automatic test_flush();
      clear_inputs();
      readEn1 = 8'h01; readAddr1 = 5'd4;
      in_valid = 1;
      @(negedge clk);                 // ISSUE
      in_valid = 0;
      @(negedge clk);                 // CAPTURE
      flush = 1;
      @(negedge clk);
      flush = 0;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || rf_rd_en !== '0) begin errors++; $display("FAIL fl_idle got ir=%h ov=%h en=%h want 1 0 0", in_ready, out_valid, rf_rd_en); end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_no_output cycle %0d got %h want 0", c, out_valid); end
      end
      // Flush wins over a simultaneous in_valid.
      readEn1 = 8'h01; readAddr1 = 5'd4;
      in_valid = 1; flush = 1;
      @(negedge clk);
      in_valid = 0; flush = 0;
      checks++; if (in_ready !== 1'b1 || rf_rd_en !== '0) begin errors++; $display("FAIL fl_priority got ir=%h en=%h want 1 0", in_ready, rf_rd_en); end
      // Normal operation resumes afterwards.
      readEn1 = 8'h08; readAddr1 = 5'd12;
      run_instr();
      checks++; if (lat != 3 || op1_o !== rf_mem[3][12]) begin errors++; $display("FAIL fl_recover got lat=%0d op1=%h want 3 %h", lat, op1_o, rf_mem[3][12]); end
      finish_hs();
   endtask

   initial begin
      for (int b = 0; b < NB; b++) begin
         for (int a = 0; a < 32; a++) begin
            for (int c = 0; c < 4; c++) begin
               rf_mem[b][a][c*32 +: 32] = {4'h6, 4'(b), 8'(a), 8'(c), 8'h5A};
            end
         end
      end
      clear_inputs();
      out_ready = 0;
      rst = 1;
      repeat (2) @(negedge clk);
      test_reset();
      rst = 0;
      @(negedge clk);
      test_no_conflict();
      test_conflict();
      test_three_rounds();
      test_share();
      test_swizzle_mods();
      test_imm();
      test_non_onehot();
      test_backpressure_reset();
      test_flush();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
